// File: rtl/mem_arbiter.sv
// Memory-port arbiter shared by the I-cache fill, D-cache fill and D-cache write-through paths.
// Read grants run a full WORDS-beat burst; dropped requests are drained before the port is re-granted.
module mem_arbiter #(
    parameter  int WORDS  = 8,
    parameter  int ADDR_W = 16,
    parameter  int DATA_W = 16,
    localparam int BEAT_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_data_valid,
    output logic [BEAT_W-1:0] i_beat,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_data_valid,
    output logic [BEAT_W-1:0] d_beat,
    output logic              d_done,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid
);
    localparam int               CNT_W = $clog2(WORDS) + 1;
    localparam int               OFF_W = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WORDS);

    typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR_D} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_issue;
    logic [CNT_W-1:0]  r_beat;
    logic [CNT_W-1:0]  r_drain;
    logic [ADDR_W-1:0] r_base;
    logic              r_last_d;

    logic w_rd, w_owner_req, w_issue, w_fwd, w_last, w_pick_i, w_pick_d, w_drain_dec;

    always_comb begin
        w_rd        = (r_state == RD_I) || (r_state == RD_D);
        w_owner_req = (r_state == RD_I) ? i_req : d_req;
        w_issue     = w_rd && (r_issue < FULL);
        // Beats are only handed to an owner that still wants them.
        w_fwd       = w_rd && w_owner_req && mem_data_valid;
        w_last      = w_fwd && (r_beat == LAST);
        w_pick_i    = (r_state == IDLE) && (r_drain == '0) && i_req && (!d_req || r_last_d);
        w_pick_d    = (r_state == IDLE) && (r_drain == '0) && d_req && !w_pick_i;
        w_drain_dec = mem_data_valid && (r_drain != '0);
    end

    assign i_grant      = (r_state == RD_I);
    assign d_grant      = (r_state == RD_D) || (r_state == WR_D);
    assign i_data_valid = (r_state == RD_I) && w_fwd;
    assign d_data_valid = (r_state == RD_D) && w_fwd;
    assign i_beat       = (r_state == RD_I) ? r_beat[BEAT_W-1:0] : '0;
    assign d_beat       = (r_state == RD_D) ? r_beat[BEAT_W-1:0] : '0;
    assign i_done       = (r_state == RD_I) && w_last;
    assign d_done       = ((r_state == RD_D) && w_last) || (r_state == WR_D);
    assign mem_enable   = w_issue || (r_state == WR_D);
    assign mem_wr       = (r_state == WR_D);
    assign mem_addr     = (r_state == WR_D) ? d_addr :
                          (w_issue ? r_base + ADDR_W'({r_issue, 1'b0}) : '0);
    assign mem_wdata    = (r_state == WR_D) ? d_wdata : '0;

    always_ff @(posedge clk) begin
        if (w_pick_i)
            r_base <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        else if (w_pick_d)
            r_base <= {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_issue  <= '0;
            r_beat   <= '0;
            r_drain  <= '0;
            r_last_d <= 1'b0;
        end else begin
            // Outstanding read issues, kept across aborts so stale beats are absorbed.
            if (w_issue && !w_drain_dec)
                r_drain <= r_drain + CNT_W'(1);
            else if (!w_issue && w_drain_dec)
                r_drain <= r_drain - CNT_W'(1);

            case (r_state)
                IDLE: begin
                    r_issue <= '0;
                    r_beat  <= '0;
                    if (w_pick_i)
                        r_state <= RD_I;
                    else if (w_pick_d)
                        r_state <= d_we ? WR_D : RD_D;
                end
                RD_I, RD_D: begin
                    if (w_last) begin
                        r_state  <= IDLE;
                        r_last_d <= (r_state == RD_D);
                        r_issue  <= '0;
                        r_beat   <= '0;
                    end else if (!w_owner_req) begin
                        r_state <= IDLE;
                        r_issue <= '0;
                        r_beat  <= '0;
                    end else begin
                        if (w_issue)
                            r_issue <= r_issue + CNT_W'(1);
                        if (w_fwd)
                            r_beat <= r_beat + CNT_W'(1);
                    end
                end
                WR_D: begin
                    r_state  <= IDLE;
                    r_last_d <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
